// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage.
// State encoding, access size masks and default trap codes.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DRAIN
    } state_e;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    localparam logic [3:0] EXC_LOAD_MISALIGN_DEF  = 4'd4;
    localparam logic [3:0] EXC_STORE_MISALIGN_DEF = 4'd6;

    typedef struct packed {
        logic        is_load;
        logic        sgn;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [3:0]  size;
        logic [31:0] wdata;
    } op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        reg_w_en;
        logic [4:0]  reg_w_rd;
        logic [31:0] reg_w_data;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [31:0] exc_pc;
    } wb_t;

    function automatic logic misaligned(
        input logic [3:0] size,
        input logic [1:0] off
    );
        return (size == STRB_H && off[0]) ||
               (size == STRB_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data bus between the memory stage and the memory system.
// Every request, including a write, gets exactly one response.
interface mem_stage_if;
    logic        MEM_REQ_VALID;
    logic        MEM_REQ_WE;
    logic [31:0] MEM_REQ_ADDR;
    logic [3:0]  MEM_REQ_STRB;
    logic [31:0] MEM_REQ_WDATA;
    logic        MEM_REQ_READY;
    logic        MEM_RESP_VALID;
    logic [31:0] MEM_RESP_RDATA;

    modport master (
        output MEM_REQ_VALID, MEM_REQ_WE, MEM_REQ_ADDR,
        output MEM_REQ_STRB, MEM_REQ_WDATA,
        input  MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_RDATA
    );

    modport slave (
        input  MEM_REQ_VALID, MEM_REQ_WE, MEM_REQ_ADDR,
        input  MEM_REQ_STRB, MEM_REQ_WDATA,
        output MEM_REQ_READY, MEM_RESP_VALID, MEM_RESP_RDATA
    );
endinterface

// File: rtl/mem_load_align.sv
// Load data extraction: lane shift, size mask and extension.
// Purely combinational; the size mask is the unshifted one.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [3:0]  size_i,
    input  logic        sgn_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;

    assign sh = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = sh;
        unique case (1'b1)
            size_i == STRB_B:
                data_o = {{24{sgn_i & sh[7]}}, sh[7:0]};
            size_i == STRB_H:
                data_o = {{16{sgn_i & sh[15]}}, sh[15:0]};
            default:
                data_o = sh;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues loads/stores on the data bus and
// produces the registered writeback / trap result.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [3:0] EXC_LOAD_MISALIGN  = EXC_LOAD_MISALIGN_DEF,
    parameter logic [3:0] EXC_STORE_MISALIGN = EXC_STORE_MISALIGN_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    output logic        MMU_WAIT,
    input  logic        CUSHION_VALID,
    input  logic [31:0] CUSHION_PC,
    input  logic        CUSHION_REG_W_EN,
    input  logic [4:0]  CUSHION_REG_W_RD,
    input  logic [31:0] CUSHION_REG_W_DATA,
    input  logic        CUSHION_MEM_R_EN,
    input  logic [4:0]  CUSHION_MEM_R_RD,
    input  logic [31:0] CUSHION_MEM_R_ADDR,
    input  logic [3:0]  CUSHION_MEM_R_STRB,
    input  logic        CUSHION_MEM_R_SIGNED,
    input  logic        CUSHION_MEM_W_EN,
    input  logic [31:0] CUSHION_MEM_W_ADDR,
    input  logic [3:0]  CUSHION_MEM_W_STRB,
    input  logic [31:0] CUSHION_MEM_W_DATA,
    input  logic        CUSHION_EXC_EN,
    input  logic [3:0]  CUSHION_EXC_CODE,
    mem_stage_if.master bus,
    output logic        WB_VALID,
    output logic [31:0] WB_PC,
    output logic        WB_REG_W_EN,
    output logic [4:0]  WB_REG_W_RD,
    output logic [31:0] WB_REG_W_DATA,
    output logic        WB_EXC_EN,
    output logic [3:0]  WB_EXC_CODE,
    output logic [31:0] WB_EXC_PC
);

    state_e      state_q, state_d;
    op_t         op_q, op_d;
    wb_t         wb_q, wb_d;
    logic        wait_c;
    logic        mem_en;
    logic [31:0] c_addr;
    logic [3:0]  c_size;
    logic [31:0] ld_data;
    logic        req;

    // A load wins over a store when both are flagged.
    assign mem_en = CUSHION_MEM_R_EN | CUSHION_MEM_W_EN;
    assign c_addr = CUSHION_MEM_R_EN ? CUSHION_MEM_R_ADDR
                                     : CUSHION_MEM_W_ADDR;
    assign c_size = CUSHION_MEM_R_EN ? CUSHION_MEM_R_STRB
                                     : CUSHION_MEM_W_STRB;

    mem_load_align u_align (
        .rdata_i (bus.MEM_RESP_RDATA),
        .off_i   (op_q.addr[1:0]),
        .size_i  (op_q.size),
        .sgn_i   (op_q.sgn),
        .data_o  (ld_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wb_q    <= wb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wb_d    = '0;
        wait_c  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (CUSHION_VALID && !FLUSH) begin
                    if (CUSHION_EXC_EN || !mem_en) begin
                        wb_d.valid      = 1'b1;
                        wb_d.pc         = CUSHION_PC;
                        wb_d.reg_w_en   = CUSHION_REG_W_EN;
                        wb_d.reg_w_rd   = CUSHION_REG_W_RD;
                        wb_d.reg_w_data = CUSHION_REG_W_DATA;
                        wb_d.exc_en     = CUSHION_EXC_EN;
                        wb_d.exc_code   = CUSHION_EXC_CODE;
                        wb_d.exc_pc     = CUSHION_PC;
                    end else if (misaligned(c_size, c_addr[1:0])) begin
                        wb_d.valid    = 1'b1;
                        wb_d.pc       = CUSHION_PC;
                        wb_d.exc_en   = 1'b1;
                        wb_d.exc_code = CUSHION_MEM_R_EN
                                      ? EXC_LOAD_MISALIGN
                                      : EXC_STORE_MISALIGN;
                        wb_d.exc_pc   = CUSHION_PC;
                    end else begin
                        wait_c       = 1'b1;
                        op_d.is_load = CUSHION_MEM_R_EN;
                        op_d.sgn     = CUSHION_MEM_R_SIGNED;
                        op_d.rd      = CUSHION_MEM_R_RD;
                        op_d.pc      = CUSHION_PC;
                        op_d.addr    = c_addr;
                        op_d.size    = c_size;
                        op_d.wdata   = CUSHION_MEM_W_DATA;
                        state_d      = S_REQ;
                    end
                end
            end
            S_REQ: begin
                wait_c = 1'b1;
                if (FLUSH) begin
                    state_d = S_IDLE;
                end else if (bus.MEM_REQ_READY) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.MEM_RESP_VALID) begin
                    state_d = S_IDLE;
                    if (!FLUSH) begin
                        wb_d.valid      = 1'b1;
                        wb_d.pc         = op_q.pc;
                        wb_d.reg_w_en   = op_q.is_load;
                        wb_d.reg_w_rd   = op_q.is_load ? op_q.rd : 5'd0;
                        wb_d.reg_w_data = op_q.is_load ? ld_data : 32'd0;
                    end
                end else begin
                    wait_c = 1'b1;
                    if (FLUSH) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.MEM_RESP_VALID) begin
                    state_d = S_IDLE;
                end else begin
                    wait_c = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req = (state_q == S_REQ);
    assign MMU_WAIT = wait_c & ~RST;

    assign bus.MEM_REQ_VALID = req;
    assign bus.MEM_REQ_WE    = req & ~op_q.is_load;
    assign bus.MEM_REQ_ADDR  = req ? {op_q.addr[31:2], 2'b00} : 32'd0;
    assign bus.MEM_REQ_STRB  = req ? op_q.size << op_q.addr[1:0] : 4'd0;
    assign bus.MEM_REQ_WDATA = req ? op_q.wdata << {op_q.addr[1:0], 3'b000}
                                   : 32'd0;

    assign WB_VALID      = wb_q.valid;
    assign WB_PC         = wb_q.pc;
    assign WB_REG_W_EN   = wb_q.reg_w_en;
    assign WB_REG_W_RD   = wb_q.reg_w_rd;
    assign WB_REG_W_DATA = wb_q.reg_w_data;
    assign WB_EXC_EN     = wb_q.exc_en;
    assign WB_EXC_CODE   = wb_q.exc_code;
    assign WB_EXC_PC     = wb_q.exc_pc;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter EXC_LOAD_MISALIGN, default 4'd4, exception code raised for a misaligned load.
REQ-002 SHALL have parameter EXC_STORE_MISALIGN, default 4'd6, exception code raised for a misaligned store.
REQ-003 SHALL have port CLK, input, 1, clock.
REQ-004 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port FLUSH, input, 1, pipeline flush.
REQ-006 SHALL have port MMU_WAIT, output, 1, stall request to the upstream cushion stage.
REQ-007 SHALL have ports CUSHION_VALID/PC/REG_W_EN/REG_W_RD/REG_W_DATA, input, 1/32/1/5/32, merged upstream result.
REQ-008 SHALL have ports CUSHION_MEM_R_EN/R_RD/R_ADDR/R_STRB/R_SIGNED, input, 1/5/32/4/1, load request; STRB is an unshifted size mask (0001, 0011, 1111).
REQ-009 SHALL have ports CUSHION_MEM_W_EN/W_ADDR/W_STRB/W_DATA, input, 1/32/4/32, store request; STRB is an unshifted size mask.
REQ-010 SHALL have ports CUSHION_EXC_EN/EXC_CODE, input, 1/4, upstream exception.
REQ-011 SHALL have ports MEM_REQ_VALID/WE/ADDR/STRB/WDATA, output, 1/1/32/4/32, bus request; ADDR is word-aligned; STRB and WDATA are lane-shifted.
REQ-012 SHALL have port MEM_REQ_READY, input, 1, bus accepts the request.
REQ-013 SHALL have ports MEM_RESP_VALID/RDATA, input, 1/32, bus response; writes also return a response.
REQ-014 SHALL have ports WB_VALID/PC/REG_W_EN/REG_W_RD/REG_W_DATA, output, 1/32/1/5/32, writeback result.
REQ-015 SHALL have ports WB_EXC_EN/EXC_CODE/EXC_PC, output, 1/4/32, exception to the trap unit.

Function
REQ-016 SHALL implement the states IDLE, REQ, RESP and DRAIN.
REQ-017 SHALL register the WB_* outputs, so each result appears exactly one cycle after the stage accepts an instruction (non-memory) or receives the bus response (memory).
REQ-018 SHALL, in IDLE with CUSHION_VALID=1 and no memory enable or CUSHION_EXC_EN=1, pass PC, REG_W_* and EXC_* through, with WB_EXC_PC=PC, and leave MMU_WAIT=0.
REQ-019 SHALL, in IDLE with CUSHION_VALID=1, a memory enable and no exception, check alignment: halfword with ADDR[0]=1, or word with ADDR[1:0]!=0, is misaligned.
REQ-020 SHALL, for a misaligned access, raise WB_EXC_EN with EXC_LOAD_MISALIGN or EXC_STORE_MISALIGN, suppress the register write and issue no bus request.
REQ-021 SHALL, for an aligned access, assert MMU_WAIT combinationally that same cycle, capture the operands and enter REQ.
REQ-022 SHALL prioritise the read and ignore the write when MEM_R_EN and MEM_W_EN are both 1.
REQ-023 SHALL, in REQ, hold MEM_REQ_VALID=1 with stable fields until MEM_REQ_READY=1, then enter RESP.
REQ-024 SHALL keep MMU_WAIT=1 throughout REQ and RESP, except in the cycle MEM_RESP_VALID=1, when MMU_WAIT=0 and the state returns to IDLE.
REQ-025 SHALL form bus STRB as the size mask shifted left by ADDR[1:0], and bus WDATA as the data shifted left by 8*ADDR[1:0].
REQ-026 SHALL extract load data as RDATA shifted right by 8*ADDR[1:0], masked to the size, then sign-extended if SIGNED else zero-extended.
REQ-027 SHALL write the extracted load data to WB_REG_W_RD=MEM_R_RD with WB_REG_W_EN=1.
REQ-028 SHALL, for a store, produce WB_VALID=1 with WB_REG_W_EN=0.
REQ-029 SHALL, when FLUSH=1 in IDLE or REQ (request not yet accepted), drop MEM_REQ_VALID next cycle, go to IDLE and clear WB_VALID.
REQ-030 SHALL, when FLUSH=1 in RESP, enter DRAIN, keep MMU_WAIT=1, discard the response, then go to IDLE with no WB_VALID.
REQ-031 SHALL give FLUSH priority over simultaneous acceptance of a new instruction and over a same-cycle MEM_RESP_VALID (response discarded, go to IDLE).
REQ-032 SHALL ignore MEM_RESP_VALID in IDLE and REQ.

Reset
REQ-033 SHALL, on RST, enter IDLE and drive every output to 0: MMU_WAIT, MEM_REQ_*, WB_*.
REQ-034 SHALL, on RST mid-transaction, abandon the transaction without entering DRAIN; the bus interface is reset in the same cycle.

Structure
REQ-035 SHALL take the state encoding, size-mask constants and default exception codes from the shared core package.
REQ-036 SHALL implement load extraction and extension in one combinational sub-module, mem_load_align.

Verification
REQ-037 SHALL cover: ALU op PC=0x100, rd=5, data=0x1234 -> WB_REG_W_DATA=0x1234 one cycle later, with MMU_WAIT never 1.
REQ-038 SHALL cover: LB signed at ADDR=0x1003, RDATA=0x80FFFFFF -> bus ADDR=0x1000, STRB=1000, WB data=0xFFFFFF80, and MMU_WAIT high from the accept cycle until the response cycle.
REQ-039 SHALL cover: SH at ADDR=0x2002, data=0xABCD, READY delayed 3 cycles -> VALID held for 4 cycles, STRB=1100, WDATA=0xABCD0000, store WB with REG_W_EN=0.
REQ-040 SHALL cover: LW at ADDR=0x3001 -> no MEM_REQ_VALID, WB_EXC_EN=1, code 4, EXC_PC=PC.
REQ-041 SHALL cover: FLUSH in RESP with the response 2 cycles later -> DRAIN, no WB_VALID, and a following instruction accepted only after the response.
REQ-042 SHALL cover: RST asserted in REQ -> all outputs 0 next cycle, state IDLE.
